// File: rtl/alu_vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_vector_sequencer_if
// Purpose : Bundles the execute-stage handshake (start/busy/done, operands,
//           results) and the shared scalar ALU connection of the vector
//           sequencer into one interface.
// Signals :
//   start, op_sel, vec_a, vec_b, lane_mask  execute stage -> sequencer
//   busy, done, vec_out, flags_out          sequencer -> execute stage
//   alu_a, alu_b, alu_sel                   sequencer -> external ALU
//   alu_out, alu_n, alu_z, alu_v, alu_c     external ALU -> sequencer
// Modports:
//   master  the sequencer's view
//   slave   the environment's view (execute stage plus ALU)
// ---------------------------------------------------------------------------
interface alu_vector_sequencer_if #(
    parameter int WIDTH = 19,
    parameter int LANES = 4
);
    logic                     start;
    logic [3:0]               op_sel;
    logic [LANES*WIDTH-1:0]   vec_a;
    logic [LANES*WIDTH-1:0]   vec_b;
    logic [LANES-1:0]         lane_mask;
    logic                     busy;
    logic                     done;
    logic [LANES*WIDTH-1:0]   vec_out;
    logic [LANES*4-1:0]       flags_out;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [3:0]               alu_sel;
    logic [WIDTH-1:0]         alu_out;
    logic                     alu_n;
    logic                     alu_z;
    logic                     alu_v;
    logic                     alu_c;

    modport master (
        input  start, op_sel, vec_a, vec_b, lane_mask,
        input  alu_out, alu_n, alu_z, alu_v, alu_c,
        output busy, done, vec_out, flags_out,
        output alu_a, alu_b, alu_sel
    );

    modport slave (
        output start, op_sel, vec_a, vec_b, lane_mask,
        output alu_out, alu_n, alu_z, alu_v, alu_c,
        input  busy, done, vec_out, flags_out,
        input  alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_vector_sequencer.sv
// ---------------------------------------------------------------------------
// alu_vector_sequencer
// Purpose : Runs one vector ALU operation as LANES scalar operations on a
//           single shared external ALU, one lane per clock. Per-lane results
//           and {N,Z,V,C} flags are gathered into registered vector outputs.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_vector_sequencer_if.master
//           start/op_sel/vec_a/vec_b/lane_mask in, busy/done/vec_out/
//           flags_out out, alu_a/alu_b/alu_sel out, alu_out/alu_n/z/v/c in
// ---------------------------------------------------------------------------
module alu_vector_sequencer #(
    parameter int WIDTH = 19,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_vector_sequencer_if.master bus
);
    localparam int              IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [IDX_W-1:0]       r_idx;
    logic [3:0]             r_opSel;
    logic [LANES*WIDTH-1:0] r_vecA;
    logic [LANES*WIDTH-1:0] r_vecB;
    logic [LANES-1:0]       r_laneMask;
    logic [LANES*WIDTH-1:0] r_vecOut;
    logic [LANES*4-1:0]     r_flagsOut;
    logic                   w_accept;
    logic [WIDTH-1:0]       w_laneA;
    logic [WIDTH-1:0]       w_laneB;

    // Operands of the lane currently being issued, picked from the latched
    // vectors by the lane index.
    assign w_laneA = r_vecA[int'(r_idx)*WIDTH +: WIDTH];
    assign w_laneB = r_vecB[int'(r_idx)*WIDTH +: WIDTH];

    assign bus.vec_out   = r_vecOut;
    assign bus.flags_out = r_flagsOut;

    // State register. Reset wins over everything, including a pending start,
    // so an interrupted operation never produces a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. DONE accepts a new start exactly like
    // IDLE so back-to-back operations need no gap cycle. The ALU ports are
    // only driven in RUN, and stay driven for masked lanes too.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_sel = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                bus.done = (r_state == S_DONE);
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_nextState = S_RUN;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_RUN: begin
                bus.busy    = 1'b1;
                bus.alu_a   = w_laneA;
                bus.alu_b   = w_laneB;
                bus.alu_sel = r_opSel;
                if (r_idx == LAST_IDX) begin
                    w_nextState = S_DONE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath. An accepted start latches the whole request; starts seen in
    // RUN never reach here because w_accept is only raised in IDLE/DONE.
    // Each RUN edge retires lane r_idx: masked-off lanes pass operand A
    // through with cleared flags, so the ALU result for them is dropped.
    // Lanes not yet retired keep the previous operation's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_opSel    <= '0;
            r_vecA     <= '0;
            r_vecB     <= '0;
            r_laneMask <= '0;
            r_vecOut   <= '0;
            r_flagsOut <= '0;
        end else if (w_accept) begin
            r_idx      <= '0;
            r_opSel    <= bus.op_sel;
            r_vecA     <= bus.vec_a;
            r_vecB     <= bus.vec_b;
            r_laneMask <= bus.lane_mask;
        end else if (r_state == S_RUN) begin
            if (r_laneMask[r_idx]) begin
                r_vecOut[int'(r_idx)*WIDTH +: WIDTH] <= bus.alu_out;
                r_flagsOut[int'(r_idx)*4 +: 4]       <= {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
            end else begin
                r_vecOut[int'(r_idx)*WIDTH +: WIDTH] <= w_laneA;
                r_flagsOut[int'(r_idx)*4 +: 4]       <= 4'b0000;
            end
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_vector_sequencer
// Purpose : Self-checking bench for alu_vector_sequencer with LANES=4,
//           WIDTH=19 and a behavioural scalar ALU attached. Expected results
//           come from a lane-by-lane model of the vector operation.
// ---------------------------------------------------------------------------
module tb_alu_vector_sequencer;
    localparam int WIDTH = 19;
    localparam int LANES = 4;
    localparam int NOBS  = 2*LANES + 4;

    typedef logic [LANES*WIDTH-1:0] vec_t;
    typedef logic [LANES*4-1:0]     flag_t;

    logic clk;
    logic rst;
    int   vectorsApplied;
    int   miscompares;

    vec_t             expVec;
    flag_t            expFlags;
    logic             obsBusy  [1:NOBS];
    logic             obsDone  [1:NOBS];
    vec_t             obsVec   [1:NOBS];
    flag_t            obsFlags [1:NOBS];
    logic [3:0]       obsSel   [1:NOBS];
    logic [WIDTH-1:0] obsA     [1:NOBS];
    logic [WIDTH-1:0] obsB     [1:NOBS];

    alu_vector_sequencer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    alu_vector_sequencer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural scalar ALU: {N,Z,V,C,result}. Carry on subtract means
    // "no borrow"; multiply flags overflow of the upper half; divide by zero
    // yields all ones with V set.
    function automatic logic [WIDTH+3:0] aluCalc(input logic [3:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0]     wide;
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   r;
        logic               v;
        logic               c;
        wide = '0; prod = '0; r = '0; v = 1'b0; c = 1'b0;
        case (sel)
            4'b0100: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0101: begin
                r = a - b;
                c = (a >= b);
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                r    = prod[WIDTH-1:0];
                c    = |prod[2*WIDTH-1:WIDTH];
                v    = c;
            end
            4'b0111: begin
                if (b == '0) begin
                    r = '1;
                    v = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            default: r = '0;
        endcase
        return {r[WIDTH-1], (r == '0), v, c, r};
    endfunction

    logic [WIDTH+3:0] aluBundle;
    assign aluBundle = aluCalc(bus.alu_sel, bus.alu_a, bus.alu_b);
    assign bus.alu_out = aluBundle[WIDTH-1:0];
    assign {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = aluBundle[WIDTH+3:WIDTH];

    // Reference model of a whole vector operation: every enabled lane gets
    // the ALU result, every disabled lane passes A through with zero flags.
    function automatic vec_t modelVec(input logic [3:0] op, input vec_t a, input vec_t b,
                                      input logic [LANES-1:0] mask);
        vec_t             r;
        logic [WIDTH+3:0] res;
        for (int l = 0; l < LANES; l++) begin
            res = aluCalc(op, a[l*WIDTH +: WIDTH], b[l*WIDTH +: WIDTH]);
            r[l*WIDTH +: WIDTH] = mask[l] ? res[WIDTH-1:0] : a[l*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    function automatic flag_t modelFlags(input logic [3:0] op, input vec_t a, input vec_t b,
                                         input logic [LANES-1:0] mask);
        flag_t            r;
        logic [WIDTH+3:0] res;
        for (int l = 0; l < LANES; l++) begin
            res = aluCalc(op, a[l*WIDTH +: WIDTH], b[l*WIDTH +: WIDTH]);
            r[l*4 +: 4] = mask[l] ? res[WIDTH+3:WIDTH] : 4'b0000;
        end
        return r;
    endfunction

    function automatic vec_t randVec();
        vec_t v;
        for (int l = 0; l < LANES; l++) begin
            v[l*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3))
                                                              : WIDTH'($urandom);
        end
        return v;
    endfunction

    // Drives one start pulse from the current negedge and records NOBS
    // negedge samples. Optionally re-pulses start (with other operands) or
    // asserts rst right after sample number pulseCycle / resetCycle.
    task automatic applyStimulus(input logic [3:0] op, input vec_t a, input vec_t b,
                                 input logic [LANES-1:0] mask, input int pulseCycle,
                                 input logic [3:0] op2, input vec_t a2, input vec_t b2,
                                 input logic [LANES-1:0] mask2, input int resetCycle);
        bus.start     = 1'b1;
        bus.op_sel    = op;
        bus.vec_a     = a;
        bus.vec_b     = b;
        bus.lane_mask = mask;
        for (int k = 1; k <= NOBS; k++) begin
            @(negedge clk);
            obsBusy[k]  = bus.busy;
            obsDone[k]  = bus.done;
            obsVec[k]   = bus.vec_out;
            obsFlags[k] = bus.flags_out;
            obsSel[k]   = bus.alu_sel;
            obsA[k]     = bus.alu_a;
            obsB[k]     = bus.alu_b;
            bus.start   = 1'b0;
            rst         = 1'b0;
            if (k == pulseCycle) begin
                bus.start     = 1'b1;
                bus.op_sel    = op2;
                bus.vec_a     = a2;
                bus.vec_b     = b2;
                bus.lane_mask = mask2;
            end
            if (k == resetCycle) rst = 1'b1;
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    // Reset held with start high: reset must win and clear every output.
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op_sel = 4'b0100;
        bus.lane_mask = '1;
        repeat (3) @(negedge clk);
        vectorsApplied++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
        end
        vectorsApplied++;
        if (bus.vec_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_vec_out: got %h expected 0", bus.vec_out);
        end
        vectorsApplied++;
        if (bus.flags_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags_out: got %h expected 0", bus.flags_out);
        end
        vectorsApplied++;
        if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_alu_ports: got a=%h b=%h sel=%h expected 0",
                     bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        vectorsApplied++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_release_idle: got %b expected 00", {bus.busy, bus.done});
        end
        expVec   = '0;
        expFlags = '0;
    endtask

    // Add across all lanes, including a zero lane for the Z flag.
    task automatic test_add();
        vec_t  a = {19'd5, 19'd0, 19'd7, 19'd3};
        vec_t  b = {19'd2, 19'd0, 19'd6, 19'd1};
        vec_t  wantVec = {19'd7, 19'd0, 19'd13, 19'd4};
        flag_t wantFlags = {4'b0000, 4'b0100, 4'b0000, 4'b0000};
        applyStimulus(4'b0100, a, b, 4'b1111, 0, 4'b0000, '0, '0, '0, 0);
        for (int k = 1; k <= NOBS; k++) begin
            vectorsApplied++;
            if ({obsBusy[k], obsDone[k]} !== {(k <= LANES), (k == LANES + 1)}) begin
                miscompares++;
                $display("[TB] FAIL add_handshake cycle %0d: got busy/done %b%b expected %b%b",
                         k, obsBusy[k], obsDone[k], (k <= LANES), (k == LANES + 1));
            end
        end
        vectorsApplied++;
        if (obsVec[LANES+1] !== wantVec) begin
            miscompares++;
            $display("[TB] FAIL add_vec_out: got %h expected %h", obsVec[LANES+1], wantVec);
        end
        vectorsApplied++;
        if (obsFlags[LANES+1] !== wantFlags) begin
            miscompares++;
            $display("[TB] FAIL add_flags_out: got %h expected %h", obsFlags[LANES+1], wantFlags);
        end
        expVec   = wantVec;
        expFlags = wantFlags;
    endtask

    // Subtract with only lane 0 enabled; the other lanes pass A through but
    // still present their operands to the ALU.
    task automatic test_sub_masked();
        vec_t  a = {19'd9, 19'd9, 19'd9, 19'd7};
        vec_t  b = {19'd3, 19'd3, 19'd3, 19'd6};
        vec_t  wantVec = {19'd9, 19'd9, 19'd9, 19'd1};
        flag_t wantFlags = {4'b0000, 4'b0000, 4'b0000, 4'b0001};
        applyStimulus(4'b0101, a, b, 4'b0001, 0, 4'b0000, '0, '0, '0, 0);
        vectorsApplied++;
        if (obsVec[LANES+1] !== wantVec) begin
            miscompares++;
            $display("[TB] FAIL sub_vec_out: got %h expected %h", obsVec[LANES+1], wantVec);
        end
        vectorsApplied++;
        if (obsFlags[LANES+1] !== wantFlags) begin
            miscompares++;
            $display("[TB] FAIL sub_flags_out: got %h expected %h", obsFlags[LANES+1], wantFlags);
        end
        for (int k = 2; k <= LANES; k++) begin
            vectorsApplied++;
            if ({obsA[k], obsB[k]} !== {19'd9, 19'd3}) begin
                miscompares++;
                $display("[TB] FAIL sub_masked_alu_drive cycle %0d: got a=%0d b=%0d expected a=9 b=3",
                         k, obsA[k], obsB[k]);
            end
        end
        expVec   = wantVec;
        expFlags = wantFlags;
    endtask

    // Multiply then divide as separate operations; alu_sel must follow the
    // latched op only during the issue cycles.
    task automatic test_mul_div();
        vec_t       a;
        vec_t       b;
        logic [3:0] ops [2] = '{4'b0110, 4'b0111};
        for (int t = 0; t < 2; t++) begin
            a = randVec();
            b = randVec();
            if (t == 0) begin
                a[0 +: WIDTH] = 19'd4;
                b[0 +: WIDTH] = 19'd2;
            end else begin
                a[WIDTH +: WIDTH] = 19'd3;
                b[WIDTH +: WIDTH] = 19'd2;
            end
            applyStimulus(ops[t], a, b, 4'b1111, 0, 4'b0000, '0, '0, '0, 0);
            expVec   = modelVec(ops[t], a, b, 4'b1111);
            expFlags = modelFlags(ops[t], a, b, 4'b1111);
            vectorsApplied++;
            if ({obsVec[LANES+1], obsFlags[LANES+1]} !== {expVec, expFlags}) begin
                miscompares++;
                $display("[TB] FAIL muldiv_result op %h: got %h/%h expected %h/%h",
                         ops[t], obsVec[LANES+1], obsFlags[LANES+1], expVec, expFlags);
            end
            for (int k = 1; k <= NOBS; k++) begin
                vectorsApplied++;
                if (obsSel[k] !== ((k <= LANES) ? ops[t] : 4'b0000)) begin
                    miscompares++;
                    $display("[TB] FAIL muldiv_alu_sel cycle %0d: got %h expected %h",
                             k, obsSel[k], (k <= LANES) ? ops[t] : 4'b0000);
                end
            end
        end
    endtask

    // A second start while lane 1 is being issued must be ignored.
    task automatic test_start_during_run();
        vec_t             a = randVec();
        vec_t             b = randVec();
        logic [LANES-1:0] mask = LANES'($urandom);
        applyStimulus(4'b0100, a, b, mask, 2, 4'b0101, ~a, ~b, ~mask, 0);
        expVec   = modelVec(4'b0100, a, b, mask);
        expFlags = modelFlags(4'b0100, a, b, mask);
        vectorsApplied++;
        if ({obsVec[LANES+1], obsFlags[LANES+1]} !== {expVec, expFlags}) begin
            miscompares++;
            $display("[TB] FAIL ignore_start_result: got %h/%h expected %h/%h",
                     obsVec[LANES+1], obsFlags[LANES+1], expVec, expFlags);
        end
        for (int k = 1; k <= NOBS; k++) begin
            vectorsApplied++;
            if ({obsBusy[k], obsDone[k]} !== {(k <= LANES), (k == LANES + 1)}) begin
                miscompares++;
                $display("[TB] FAIL ignore_start_handshake cycle %0d: got %b%b expected %b%b",
                         k, obsBusy[k], obsDone[k], (k <= LANES), (k == LANES + 1));
            end
        end
        vectorsApplied++;
        if ({obsSel[3], obsA[3]} !== {4'b0100, a[2*WIDTH +: WIDTH]}) begin
            miscompares++;
            $display("[TB] FAIL ignore_start_operands: got sel=%h a=%h expected sel=4 a=%h",
                     obsSel[3], obsA[3], a[2*WIDTH +: WIDTH]);
        end
    endtask

    // Start presented in the DONE cycle launches the next op with no gap.
    task automatic test_back_to_back();
        vec_t       a1 = randVec();
        vec_t       b1 = randVec();
        vec_t       a2 = randVec();
        vec_t       b2 = randVec();
        logic [3:0] op2 = 4'(4 + $urandom_range(0, 3));
        vec_t       vec1 = modelVec(4'b0101, a1, b1, 4'b1011);
        vec_t       vec2 = modelVec(op2, a2, b2, 4'b1111);
        int         doneCount = 0;
        applyStimulus(4'b0101, a1, b1, 4'b1011, LANES + 1, op2, a2, b2, 4'b1111, 0);
        for (int k = 1; k <= NOBS; k++) begin
            doneCount += int'(obsDone[k]);
            vectorsApplied++;
            if ({obsBusy[k], obsDone[k]} !== {((k <= LANES) || (k >= LANES + 2 && k <= 2*LANES + 1)),
                                              (k == LANES + 1 || k == 2*LANES + 2)}) begin
                miscompares++;
                $display("[TB] FAIL b2b_handshake cycle %0d: got busy/done %b%b", k, obsBusy[k], obsDone[k]);
            end
        end
        vectorsApplied++;
        if (doneCount !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneCount);
        end
        vectorsApplied++;
        if ({obsVec[LANES+1], obsVec[LANES+2]} !== {vec1, vec1}) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_result: got %h,%h expected %h", obsVec[LANES+1], obsVec[LANES+2], vec1);
        end
        vectorsApplied++;
        if (obsVec[2*LANES+2] !== vec2) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_result: got %h expected %h", obsVec[2*LANES+2], vec2);
        end
        expVec   = vec2;
        expFlags = modelFlags(op2, a2, b2, 4'b1111);
    endtask

    // Reset while lane 2 is being issued: everything clears, no done follows.
    task automatic test_reset_mid_run();
        applyStimulus(4'b0100, randVec(), randVec(), 4'b1111, 0, 4'b0000, '0, '0, '0, 3);
        vectorsApplied++;
        if ({obsBusy[4], obsDone[4], obsSel[4], obsA[4], obsB[4]} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset_ctrl: got busy=%b done=%b sel=%h a=%h b=%h expected 0",
                     obsBusy[4], obsDone[4], obsSel[4], obsA[4], obsB[4]);
        end
        vectorsApplied++;
        if ({obsVec[4], obsFlags[4]} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset_data: got %h/%h expected 0", obsVec[4], obsFlags[4]);
        end
        for (int k = 5; k <= NOBS; k++) begin
            vectorsApplied++;
            if ({obsBusy[k], obsDone[k]} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL midrun_reset_quiet cycle %0d: got %b%b expected 00", k, obsBusy[k], obsDone[k]);
            end
        end
        expVec   = '0;
        expFlags = '0;
    endtask

    // Random ops: lane-by-lane progression of the outputs, ALU drive and
    // handshake timing, checked against the vector model.
    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [3:0]       op   = 4'(4 + $urandom_range(0, 3));
            vec_t             a    = randVec();
            vec_t             b    = randVec();
            logic [LANES-1:0] mask = LANES'($urandom);
            vec_t             newVec   = modelVec(op, a, b, mask);
            flag_t            newFlags = modelFlags(op, a, b, mask);
            vec_t             wantVec;
            flag_t            wantFlags;
            applyStimulus(op, a, b, mask, 0, 4'b0000, '0, '0, '0, 0);
            for (int k = 1; k <= LANES + 1; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    wantVec[l*WIDTH +: WIDTH] = (l < k - 1) ? newVec[l*WIDTH +: WIDTH] : expVec[l*WIDTH +: WIDTH];
                    wantFlags[l*4 +: 4]       = (l < k - 1) ? newFlags[l*4 +: 4] : expFlags[l*4 +: 4];
                end
                vectorsApplied++;
                if ({obsVec[k], obsFlags[k]} !== {wantVec, wantFlags}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_outputs op %0d cycle %0d: got %h/%h expected %h/%h",
                             it, k, obsVec[k], obsFlags[k], wantVec, wantFlags);
                end
                vectorsApplied++;
                if ({obsBusy[k], obsDone[k]} !== {(k <= LANES), (k == LANES + 1)}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_handshake op %0d cycle %0d: got %b%b", it, k, obsBusy[k], obsDone[k]);
                end
                if (k <= LANES) begin
                    vectorsApplied++;
                    if ({obsSel[k], obsA[k], obsB[k]} !== {op, a[(k-1)*WIDTH +: WIDTH], b[(k-1)*WIDTH +: WIDTH]}) begin
                        miscompares++;
                        $display("[TB] FAIL rand_alu_drive op %0d cycle %0d: got sel=%h a=%h b=%h", it, k,
                                 obsSel[k], obsA[k], obsB[k]);
                    end
                end
            end
            expVec   = newVec;
            expFlags = newFlags;
        end
    endtask

    // Test sequence.
    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.op_sel     = '0;
        bus.vec_a      = '0;
        bus.vec_b      = '0;
        bus.lane_mask  = '0;
        expVec         = '0;
        expFlags       = '0;
        test_reset();
        test_add();
        test_sub_masked();
        test_mul_div();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end
endmodule
